intra_nbr_fetch: RTL and testbench

Neighbour-pixel fetch stage sitting directly upstream of `intrapred`. For each macroblock (MB) it tracks the MB position, assembles the luma top row, left column and top-left neighbour pixels from a line buffer and a left-column register, and flags their availability. It presents them to `intrapred` over a valid/ready handshake. After reconstruction it accepts the MB's bottom row and right column back, updating its storage for the next MB.

---
 rtl/intra_nbr_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_intra_nbr_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/intra_nbr_fetch.sv
// Neighbour-pixel fetch stage feeding intrapred: MB position tracking, line buffer, left/top-left edges.
// Define INTRA_NBR_TOPRIGHT_EN to add the top-right neighbour output (one extra read cycle).
module intra_nbr_fetch #(
   parameter int PIC_WIDTH_MB = 120,
   parameter int PIC_MBS      = 8160
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         start,
   input  logic [12:0]  mbnumber,
   output logic         nbr_valid,
   input  logic         nbr_ready,
   output logic [127:0] nbr_top,
   output logic [127:0] nbr_left,
   output logic [7:0]   nbr_topleft,
   output logic         avail_top,
   output logic         avail_left,
   output logic         avail_topleft,
`ifdef INTRA_NBR_TOPRIGHT_EN
   output logic [31:0]  nbr_topright,
   output logic         avail_topright,
`endif
   input  logic         upd_valid,
   input  logic [127:0] upd_bottom,
   input  logic [127:0] upd_right,
   output logic         seq_err
);

   localparam int XW = (PIC_WIDTH_MB > 1) ? $clog2(PIC_WIDTH_MB) : 1;
   localparam logic [XW-1:0]  X_LAST  = XW'(PIC_WIDTH_MB - 1);
   localparam logic [XW-1:0]  X_ONE   = XW'(1);
   localparam logic [12:0]    MB_LAST = 13'(PIC_MBS - 1);
   localparam logic [127:0]   FILL    = {16{8'h80}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_READ2,
      S_OUT,
      S_WAIT_UPD
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [127:0]   r_lb [PIC_WIDTH_MB];
   logic [127:0]   r_lb_rdata;
   logic [XW-1:0]  w_rd_addr;

   logic [XW-1:0]  r_mb_x;
   logic [12:0]    r_mb_y;
   logic [12:0]    r_mb_idx;
   logic [12:0]    r_prev_mb;
   logic           r_seq_err;

   logic [127:0]   r_left;
   logic [7:0]     r_topleft;
   logic [7:0]     r_top_b15;

   logic           r_avail_top;
   logic           r_avail_left;
   logic [127:0]   r_nbr_top;
   logic [127:0]   r_nbr_left;
   logic [7:0]     r_nbr_topleft;

   logic           w_first;
   logic [XW-1:0]  w_pos_x;
   logic           w_accept;
   logic           w_update;

`ifdef INTRA_NBR_TOPRIGHT_EN
   logic           r_avail_tr;
   logic [31:0]    r_nbr_topright;
`endif

   // mbnumber 0 restarts the picture, so its position is forced to the origin
   assign w_first  = (mbnumber == 13'd0);
   assign w_pos_x  = w_first ? '0 : r_mb_x;
   assign w_accept = enable && (r_state == S_IDLE) && start;
   assign w_update = enable && (r_state == S_WAIT_UPD) && upd_valid;

   always_comb begin
      w_rd_addr = r_mb_x;
      if (r_state == S_IDLE) begin
         w_rd_addr = w_pos_x;
      end
`ifdef INTRA_NBR_TOPRIGHT_EN
      if (r_state == S_READ) begin
         w_rd_addr = (r_mb_x == X_LAST) ? '0 : (r_mb_x + X_ONE);
      end
`endif
   end

   // Line buffer: one bottom row per MB column, registered read
   always_ff @(posedge clk) begin
      if (enable) begin
         if (w_update) begin
            r_lb[r_mb_x] <= upd_bottom;
         end
         r_lb_rdata <= r_lb[w_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else if (enable) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_READ;
            end
         end
         S_READ: begin
`ifdef INTRA_NBR_TOPRIGHT_EN
            w_state_next = S_READ2;
`else
            w_state_next = S_OUT;
`endif
         end
         S_READ2: begin
            w_state_next = S_OUT;
         end
         S_OUT: begin
            if (nbr_ready) begin
               w_state_next = S_WAIT_UPD;
            end
         end
         S_WAIT_UPD: begin
            if (upd_valid) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      nbr_valid = (r_state == S_OUT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mb_x        <= '0;
         r_mb_y        <= '0;
         r_mb_idx      <= '0;
         r_prev_mb     <= '1;
         r_seq_err     <= 1'b0;
         r_left        <= '0;
         r_topleft     <= '0;
         r_top_b15     <= '0;
         r_avail_top   <= 1'b0;
         r_avail_left  <= 1'b0;
         r_nbr_top     <= '0;
         r_nbr_left    <= '0;
         r_nbr_topleft <= '0;
      end else if (enable) begin
         if (w_accept) begin
            r_prev_mb <= mbnumber;
            if (w_first) begin
               r_mb_x   <= '0;
               r_mb_y   <= '0;
               r_mb_idx <= '0;
            end else if (mbnumber != r_prev_mb + 13'd1) begin
               r_seq_err <= 1'b1;
            end
            r_avail_top  <= !w_first && (r_mb_y != 13'd0);
            r_avail_left <= !w_first && (r_mb_x != '0);
         end

         if (r_state == S_READ) begin
            r_top_b15     <= r_lb_rdata[127:120];
            r_nbr_top     <= r_avail_top  ? r_lb_rdata : FILL;
            r_nbr_left    <= r_avail_left ? r_left     : FILL;
            r_nbr_topleft <= (r_avail_top && r_avail_left) ? r_topleft : 8'h80;
         end

         // Raw top byte 15 becomes the next MB's top-left; availability gating hides stale values
         if (w_update) begin
            r_topleft <= r_top_b15;
            r_left    <= upd_right;
            if (r_mb_idx == MB_LAST) begin
               r_mb_x   <= '0;
               r_mb_y   <= '0;
               r_mb_idx <= '0;
            end else begin
               r_mb_idx <= r_mb_idx + 13'd1;
               if (r_mb_x == X_LAST) begin
                  r_mb_x <= '0;
                  r_mb_y <= r_mb_y + 13'd1;
               end else begin
                  r_mb_x <= r_mb_x + X_ONE;
               end
            end
         end
      end
   end

`ifdef INTRA_NBR_TOPRIGHT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_avail_tr     <= 1'b0;
         r_nbr_topright <= '0;
      end else if (enable) begin
         if (w_accept) begin
            r_avail_tr <= !w_first && (r_mb_y != 13'd0) && (w_pos_x != X_LAST);
         end
         if (r_state == S_READ2) begin
            r_nbr_topright <= r_avail_tr ? r_lb_rdata[31:0] : {4{8'h80}};
         end
      end
   end

   assign nbr_topright   = r_nbr_topright;
   assign avail_topright = r_avail_tr;
`endif

   assign nbr_top       = r_nbr_top;
   assign nbr_left      = r_nbr_left;
   assign nbr_topleft   = r_nbr_topleft;
   assign avail_top     = r_avail_top;
   assign avail_left    = r_avail_left;
   assign avail_topleft = r_avail_top && r_avail_left;
   assign seq_err       = r_seq_err;

endmodule

// File: tb/tb_intra_nbr_fetch.sv
// Directed bench for intra_nbr_fetch with a 4-MB-wide, 12-MB picture.
module tb_intra_nbr_fetch;

   localparam int W   = 4;
   localparam int MBS = 12;
   localparam logic [127:0] FILL = {16{8'h80}};
   localparam logic [127:0] R0   = 128'h1F1E1D1C1B1A19181716151413121110;

   logic         clk = 1'b0;
   logic         reset, enable, start, nbr_ready, upd_valid;
   logic [12:0]  mbnumber;
   logic [127:0] upd_bottom, upd_right;
   logic         nbr_valid, avail_top, avail_left, avail_topleft, seq_err;
   logic [127:0] nbr_top, nbr_left;
   logic [7:0]   nbr_topleft;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   intra_nbr_fetch #(.PIC_WIDTH_MB(W), .PIC_MBS(MBS)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .start         (start),
      .mbnumber      (mbnumber),
      .nbr_valid     (nbr_valid),
      .nbr_ready     (nbr_ready),
      .nbr_top       (nbr_top),
      .nbr_left      (nbr_left),
      .nbr_topleft   (nbr_topleft),
      .avail_top     (avail_top),
      .avail_left    (avail_left),
      .avail_topleft (avail_topleft),
      .upd_valid     (upd_valid),
      .upd_bottom    (upd_bottom),
      .upd_right     (upd_right),
      .seq_err       (seq_err)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [127:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [12:0] mb);
      mbnumber = mb;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check("valid_in_read", 128'(nbr_valid), 128'(1'b0));
      tick();
      check("valid_at_2", 128'(nbr_valid), 128'(1'b1));
      $display("fetch mb=%0d avail t/l/tl=%0b%0b%0b top=%h left=%h tl=%h seq_err=%0b",
               mb, avail_top, avail_left, avail_topleft, nbr_top, nbr_left, nbr_topleft, seq_err);
   endtask

   task automatic take();
      nbr_ready = 1'b1;
      tick();
      nbr_ready = 1'b0;
      check("valid_drop", 128'(nbr_valid), 128'(1'b0));
   endtask

   task automatic update(input logic [127:0] b, input logic [127:0] r);
      upd_bottom = b;
      upd_right  = r;
      upd_valid  = 1'b1;
      tick();
      upd_valid  = 1'b0;
   endtask

   task automatic check_avail(input string tag, input logic t, input logic l);
      check({tag, "_avail_top"},  128'(avail_top),     128'(t));
      check({tag, "_avail_left"}, 128'(avail_left),    128'(l));
      check({tag, "_avail_tl"},   128'(avail_topleft), 128'(t & l));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; start = 1'b0; nbr_ready = 1'b0; upd_valid = 1'b0;
      mbnumber = '0; upd_bottom = '0; upd_right = '0;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_valid", 128'(nbr_valid), 128'(1'b0));
      check("rst_seq_err", 128'(seq_err), 128'(1'b0));
      check_avail("rst", 1'b0, 1'b0);
      check("rst_top", nbr_top, '0);
      check("rst_left", nbr_left, '0);
      check("rst_tl", 128'(nbr_topleft), '0);

      // MB 0: nothing available
      fetch(13'd0);
      check_avail("mb0", 1'b0, 1'b0);
      check("mb0_top", nbr_top, FILL);
      check("mb0_left", nbr_left, FILL);
      check("mb0_tl", 128'(nbr_topleft), 128'(8'h80));
      take();
      update(rep(8'hA0), R0);

      // MB 1: left only
      fetch(13'd1);
      check_avail("mb1", 1'b0, 1'b1);
      check("mb1_left", nbr_left, R0);
      check("mb1_top", nbr_top, FILL);
      check("mb1_tl", 128'(nbr_topleft), 128'(8'h80));
      take();
      update(rep(8'hA1), rep(8'h21));
      fetch(13'd2);
      take();
      update(rep(8'hA2), rep(8'h22));
      fetch(13'd3);
      check("mb3_left", nbr_left, rep(8'h22));
      take();
      update(rep(8'hA3), rep(8'h23));

      // MB 4: row wrap, top only
      fetch(13'd4);
      check_avail("mb4", 1'b1, 1'b0);
      check("mb4_top", nbr_top, rep(8'hA0));
      check("mb4_left", nbr_left, FILL);
      take();
      update(rep(8'hB4), rep(8'h24));

      // MB 5: everything available
      fetch(13'd5);
      check_avail("mb5", 1'b1, 1'b1);
      check("mb5_top", nbr_top, rep(8'hA1));
      check("mb5_left", nbr_left, rep(8'h24));
      check("mb5_tl", 128'(nbr_topleft), 128'(8'hA0));
      check("mb5_seq_err", 128'(seq_err), 128'(1'b0));

      // Backpressure with enable toggling
      for (int i = 0; i < 5; i++) begin
         enable = (i == 1 || i == 2) ? 1'b0 : 1'b1;
         tick();
         check("hold_valid", 128'(nbr_valid), 128'(1'b1));
         check("hold_top", nbr_top, rep(8'hA1));
         check("hold_tl", 128'(nbr_topleft), 128'(8'hA0));
      end
      enable = 1'b0;
      nbr_ready = 1'b1;
      tick();
      check("stall_no_xfer", 128'(nbr_valid), 128'(1'b1));
      enable = 1'b1;
      take();
      update(rep(8'hC5), rep(8'h25));

      // Reset while in OUT
      fetch(13'd6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_out_valid", 128'(nbr_valid), 128'(1'b0));
      fetch(13'd0);
      check_avail("re_mb0", 1'b0, 1'b0);
      check("re_mb0_top", nbr_top, FILL);
      check("re_mb0_left", nbr_left, FILL);
      check("re_mb0_tl", 128'(nbr_topleft), 128'(8'h80));
      take();
      update(rep(8'hD0), rep(8'h30));
      fetch(13'd1);
      take();
      update(rep(8'hD1), rep(8'h31));
      fetch(13'd2);
      check("seq_before", 128'(seq_err), 128'(1'b0));
      take();
      update(rep(8'hD2), rep(8'h32));

      // Out-of-sequence mbnumber: flag set, position follows the counters (x=3, y=0)
      fetch(13'd7);
      check("seq_set", 128'(seq_err), 128'(1'b1));
      check_avail("mb7", 1'b0, 1'b1);
      check("mb7_left", nbr_left, rep(8'h32));
      take();
      update(rep(8'hE7), rep(8'h37));
      fetch(13'd8);
      check("seq_sticky", 128'(seq_err), 128'(1'b1));
      check_avail("mb8", 1'b1, 1'b0);
      check("mb8_top", nbr_top, rep(8'hD0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("seq_cleared", 128'(seq_err), 128'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
